// File: rtl/store_pkg.sv
// Shared types and the sub-word merge used by the store buffer.
package store_pkg;

    typedef enum logic [1:0] {
        ST_B = 2'b00,
        ST_H = 2'b01,
        ST_W = 2'b10
    } store_type_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        READ  = 2'b01,
        WAIT  = 2'b10,
        WRITE = 2'b11
    } sb_state_t;

    // typ is kept raw so the 2'b11 encoding survives as a word store
    typedef struct packed {
        logic [31:0] addr;
        logic [1:0]  typ;
        logic [31:0] data;
    } sb_entry_t;

    function automatic logic [31:0] merge_word(input logic [31:0] r,
                                               input logic [31:0] d,
                                               input logic [1:0]  addr_lo,
                                               input logic [1:0]  typ);
        logic [31:0] w;
        w = d;
        case (typ)
            ST_B: begin
                case (addr_lo)
                    2'd0:    w = {r[31:8], d[7:0]};
                    2'd1:    w = {r[31:16], d[7:0], r[7:0]};
                    2'd2:    w = {r[31:24], d[7:0], r[15:0]};
                    default: w = {d[7:0], r[23:0]};
                endcase
            end
            ST_H: begin
                if (addr_lo[1]) begin
                    w = {d[15:0], r[15:0]};
                end else begin
                    w = {r[31:16], d[15:0]};
                end
            end
            default: w = d;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/store_buffer_if.sv
// Store-side, load-probe and data-RAM signals of the store buffer.
interface store_buffer_if;
    logic        st_valid;
    logic        st_ready;
    logic [31:0] st_addr;
    logic [1:0]  st_type;
    logic [31:0] st_data;
    logic [31:0] ld_addr;
    logic        ld_hit;
    logic        mem_req;
    logic        mem_we;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic [31:0] mem_rdata;
    logic        mem_rvalid;

    modport master (
        input  st_valid, st_addr, st_type, st_data, ld_addr,
        input  mem_gnt, mem_rdata, mem_rvalid,
        output st_ready, ld_hit, mem_req, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output st_valid, st_addr, st_type, st_data, ld_addr,
        output mem_gnt, mem_rdata, mem_rvalid,
        input  st_ready, ld_hit, mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/store_fifo.sv
// DEPTH-entry store queue; exposes head, occupancy and per-slot addresses
// so the top level can compare loads against every pending store.
module store_fifo
    import store_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  sb_entry_t              push_entry,
    input  logic                   pop,
    output sb_entry_t              head,
    output logic [CW-1:0]          count,
    output logic [DEPTH-1:0]       valid,
    output logic [DEPTH-1:0][31:0] addr
);
    localparam int PW = $clog2(DEPTH);

    sb_entry_t        mem_r [DEPTH];
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic [DEPTH-1:0] valid_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign do_push_s = push && (count_r != CW'(DEPTH));
    assign do_pop_s  = pop && (count_r != {CW{1'b0}});

    // Storage, pointers (wrapping modulo DEPTH) and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
            valid_r  <= {DEPTH{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r]   <= push_entry;
                valid_r[wr_ptr_r] <= 1'b1;
                wr_ptr_r          <= wr_ptr_r + PW'(1);
            end
            if (do_pop_s) begin
                valid_r[rd_ptr_r] <= 1'b0;
                rd_ptr_r          <= rd_ptr_r + PW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Slot addresses for the load-hazard compare
    always_comb begin
        addr = '0;
        for (int i = 0; i < DEPTH; i++) begin
            addr[i] = mem_r[i].addr;
        end
    end

    assign head  = mem_r[rd_ptr_r];
    assign count = count_r;
    assign valid = valid_r;

endmodule

// File: rtl/store_buffer.sv
// Store buffer: queues retired stores and commits them to a single-port
// word RAM, using read-modify-write for byte and half stores.
module store_buffer
    import store_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    store_buffer_if.master bus,
    output logic [CW-1:0] count,
    output logic          empty
);
    sb_state_t             state_r;
    logic                  mem_req_r;
    logic                  mem_we_r;
    logic [29:0]           mem_addr_r;
    logic [31:0]           mem_wdata_r;
    sb_entry_t             head_s;
    sb_entry_t             push_entry_s;
    logic                  push_s;
    logic                  pop_s;
    logic                  empty_s;
    logic                  hit_s;
    logic [CW-1:0]         count_s;
    logic [DEPTH-1:0]      valid_s;
    logic [DEPTH-1:0][31:0] addr_s;
    logic                  unused_s;

    assign push_s       = bus.st_valid && bus.st_ready;
    assign pop_s        = (state_r == WRITE) && bus.mem_gnt;
    assign empty_s      = (count_s == {CW{1'b0}});
    assign push_entry_s = '{addr: bus.st_addr, typ: bus.st_type, data: bus.st_data};

    store_fifo #(.DEPTH(DEPTH), .CW(CW)) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push_s),
        .push_entry (push_entry_s),
        .pop        (pop_s),
        .head       (head_s),
        .count      (count_s),
        .valid      (valid_s),
        .addr       (addr_s)
    );

    // Commit FSM for the head entry; memory outputs are registered here
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= 30'd0;
            mem_wdata_r <= 32'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (!empty_s) begin
                        mem_req_r  <= 1'b1;
                        mem_addr_r <= head_s.addr[31:2];
                        if (head_s.typ[1]) begin
                            mem_we_r    <= 1'b1;
                            mem_wdata_r <= head_s.data;
                            state_r     <= WRITE;
                        end else begin
                            mem_we_r <= 1'b0;
                            state_r  <= READ;
                        end
                    end else begin
                        mem_req_r <= 1'b0;
                    end
                end
                READ: begin
                    if (bus.mem_gnt) begin
                        mem_req_r <= 1'b0;
                        state_r   <= WAIT;
                    end else begin
                        state_r <= READ;
                    end
                end
                WAIT: begin
                    if (bus.mem_rvalid) begin
                        mem_req_r   <= 1'b1;
                        mem_we_r    <= 1'b1;
                        mem_wdata_r <= merge_word(bus.mem_rdata, head_s.data,
                                                  head_s.addr[1:0], head_s.typ);
                        state_r     <= WRITE;
                    end else begin
                        state_r <= WAIT;
                    end
                end
                WRITE: begin
                    if (bus.mem_gnt) begin
                        mem_req_r <= 1'b0;
                        mem_we_r  <= 1'b0;
                        state_r   <= IDLE;
                    end else begin
                        state_r <= WRITE;
                    end
                end
                default: begin
                    mem_req_r <= 1'b0;
                    mem_we_r  <= 1'b0;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

    // Load hazard: any pending store (in-flight head included) to the same word
    always_comb begin
        hit_s = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            hit_s = hit_s | (valid_s[i] && (addr_s[i][31:2] == bus.ld_addr[31:2]));
        end
    end

    assign unused_s      = ^bus.ld_addr[1:0];
    assign bus.ld_hit    = hit_s;
    assign bus.st_ready  = (count_s != CW'(DEPTH));
    assign bus.mem_req   = mem_req_r;
    assign bus.mem_we    = mem_we_r;
    assign bus.mem_addr  = mem_addr_r;
    assign bus.mem_wdata = mem_wdata_r;
    assign count         = count_s;
    assign empty         = empty_s;

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer with a small RAM responder and write log.
module tb_store_buffer;
    logic        clk;
    logic        rst_n;
    logic [2:0]  count;
    logic        empty;
    logic        gnt_en;
    logic        rv_en;
    logic        rv_force;
    logic        rd_pend;
    logic [31:0] mem_word;
    logic [61:0] wq [$];
    logic [29:0] rd_addr;
    int          read_cnt;
    int          checks;
    int          failures;

    store_buffer_if bus ();

    store_buffer #(.DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .count (count),
        .empty (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.mem_gnt = gnt_en & bus.mem_req;

    // RAM model: logs grants and returns read data one cycle after a read grant
    always @(negedge clk) begin
        #2;
        bus.mem_rvalid = rv_force;
        if (rd_pend && rv_en) begin
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = mem_word;
            rd_pend        = 1'b0;
        end
        if (bus.mem_req && bus.mem_gnt && rst_n) begin
            if (bus.mem_we) begin
                wq.push_back({bus.mem_addr, bus.mem_wdata});
            end else begin
                read_cnt++;
                rd_addr = bus.mem_addr;
                rd_pend = 1'b1;
            end
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push_store(input logic [31:0] a, input logic [1:0] t, input logic [31:0] d);
        int n = 0;
        bus.st_valid = 1'b1;
        bus.st_addr  = a;
        bus.st_type  = t;
        bus.st_data  = d;
        while (!bus.st_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        bus.st_valid = 1'b0;
        if (n >= 200) check_val("push_timeout", {31'd0, bus.st_ready}, 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (!(empty && !bus.mem_req) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_val(tag, {31'd0, empty}, 32'd1);
    endtask

    task automatic clear_log();
        wq.delete();
        read_cnt = 0;
        rd_addr  = 30'd0;
    endtask

    task automatic rmw_case(input string tag, input logic [31:0] a, input logic [1:0] t,
                            input logic [31:0] d, input logic [29:0] ea, input logic [31:0] ed);
        clear_log();
        push_store(a, t, d);
        wait_idle({tag, "_drain"});
        check_val({tag, "_reads"}, read_cnt, 32'd1);
        check_val({tag, "_raddr"}, {2'b00, rd_addr}, {2'b00, ea});
        check_val({tag, "_nwr"}, wq.size(), 32'd1);
        check_val({tag, "_waddr"}, {2'b00, wq[0][61:32]}, {2'b00, ea});
        check_val({tag, "_wdata"}, wq[0][31:0], ed);
    endtask

    initial begin
        checks = 0; failures = 0;
        rst_n = 1'b0; gnt_en = 1'b1; rv_en = 1'b1; rv_force = 1'b0; rd_pend = 1'b0;
        mem_word = 32'h1122_3344;
        bus.st_valid = 1'b0; bus.st_addr = 32'd0; bus.st_type = 2'd0; bus.st_data = 32'd0;
        bus.ld_addr = 32'h0000_0FF0; bus.mem_rdata = 32'd0; bus.mem_rvalid = 1'b0;
        clear_log();
        repeat (2) @(negedge clk);
        check_val("rst_count", {29'd0, count}, 32'd0);
        check_val("rst_empty", {31'd0, empty}, 32'd1);
        check_val("rst_ready", {31'd0, bus.st_ready}, 32'd1);
        check_val("rst_req", {31'd0, bus.mem_req}, 32'd0);
        check_val("rst_we", {31'd0, bus.mem_we}, 32'd0);
        check_val("rst_maddr", {2'b00, bus.mem_addr}, 32'd0);
        check_val("rst_wdata", bus.mem_wdata, 32'd0);
        check_val("rst_ldhit", {31'd0, bus.ld_hit}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Word store: one write, no read, two-cycle request latency
        clear_log();
        push_store(32'h0000_0100, 2'b10, 32'hDEAD_BEEF);
        check_val("w_lat_req0", {31'd0, bus.mem_req}, 32'd0);
        check_val("w_count1", {29'd0, count}, 32'd1);
        @(negedge clk);
        check_val("w_lat_req1", {31'd0, bus.mem_req}, 32'd1);
        check_val("w_we", {31'd0, bus.mem_we}, 32'd1);
        check_val("w_maddr", {2'b00, bus.mem_addr}, 32'h40);
        check_val("w_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
        wait_idle("w_drain");
        check_val("w_reads", read_cnt, 32'd0);
        check_val("w_nwr", wq.size(), 32'd1);
        check_val("w_count0", {29'd0, count}, 32'd0);

        // Sub-word read-modify-write cases, memory word 0x11223344
        rmw_case("b103", 32'h0000_0103, 2'b00, 32'h0000_00AB, 30'h40, 32'hAB22_3344);
        rmw_case("b101", 32'h0000_0101, 2'b00, 32'h0000_00AB, 30'h40, 32'h1122_AB44);
        rmw_case("h202", 32'h0000_0202, 2'b01, 32'h0000_CAFE, 30'h80, 32'hCAFE_3344);
        rmw_case("h200", 32'h0000_0200, 2'b01, 32'h0000_CAFE, 30'h80, 32'h1122_CAFE);

        // Type 11 behaves as a word store
        clear_log();
        push_store(32'h0000_0302, 2'b11, 32'h1234_5678);
        wait_idle("t3_drain");
        check_val("t3_reads", read_cnt, 32'd0);
        check_val("t3_waddr", {2'b00, wq[0][61:32]}, 32'hC0);
        check_val("t3_wdata", wq[0][31:0], 32'h1234_5678);

        // Backpressure: fill the buffer with grants held off
        clear_log();
        gnt_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push_store(32'h0000_0400 + 32'(4 * i), 2'b10, 32'(i + 1));
        end
        bus.st_valid = 1'b1; bus.st_addr = 32'h0000_0410; bus.st_type = 2'b10; bus.st_data = 32'd5;
        repeat (3) @(negedge clk);
        check_val("full_count", {29'd0, count}, 32'd4);
        check_val("full_ready", {31'd0, bus.st_ready}, 32'd0);
        check_val("full_nwr", wq.size(), 32'd0);
        gnt_en = 1'b1;
        for (int n = 0; n < 200 && !bus.st_ready; n++) @(negedge clk);
        @(negedge clk);
        bus.st_valid = 1'b0;
        wait_idle("full_drain");
        check_val("full_total", wq.size(), 32'd5);
        for (int i = 0; i < 5; i++) begin
            check_val("full_oaddr", {2'b00, wq[i][61:32]}, 32'h100 + 32'(i));
            check_val("full_odata", wq[i][31:0], 32'(i + 1));
        end

        // Load hazard against a pending byte store
        clear_log();
        gnt_en = 1'b0;
        push_store(32'h0000_0104, 2'b00, 32'h0000_0055);
        bus.ld_addr = 32'h0000_0107;
        #1 check_val("hit_same", {31'd0, bus.ld_hit}, 32'd1);
        bus.ld_addr = 32'h0000_0108;
        #1 check_val("hit_next", {31'd0, bus.ld_hit}, 32'd0);
        gnt_en = 1'b1;
        wait_idle("hit_drain");
        bus.ld_addr = 32'h0000_0107;
        #1 check_val("hit_after", {31'd0, bus.ld_hit}, 32'd0);
        check_val("hit_wdata", wq[0][31:0], 32'h1122_3355);

        // Reset while waiting for read data
        @(negedge clk);
        clear_log();
        rv_en = 1'b0;
        push_store(32'h0000_0010, 2'b00, 32'h0000_0077);
        for (int n = 0; n < 50 && read_cnt == 0; n++) @(negedge clk);
        @(negedge clk);
        check_val("rstw_inwait", {29'd0, count}, 32'd1);
        #3 rst_n = 1'b0;
        #1;
        check_val("rstw_req", {31'd0, bus.mem_req}, 32'd0);
        check_val("rstw_count", {29'd0, count}, 32'd0);
        check_val("rstw_empty", {31'd0, empty}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        rd_pend = 1'b0;
        clear_log();
        rv_force = 1'b1;
        @(negedge clk);
        rv_force = 1'b0;
        repeat (5) @(negedge clk);
        check_val("rstw_nowr", wq.size(), 32'd0);
        check_val("rstw_req2", {31'd0, bus.mem_req}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
